// File: rtl/pe_array_pkg.sv
// Shared types and defaults for the PE-array weight path.
// The state encoding is kept here so that every block decodes the same values.
package pe_array_pkg;

    localparam int DEF_DATA_WIDTH   = 16;
    localparam int DEF_BUFFER_DEPTH = 16;
    localparam int KS_W             = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FLUSH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_e;

endpackage

// File: rtl/weight_load_sched_rd_seq.sv
// RUN-phase read sequencer: word address r and pass counter, frozen whenever advance is low.
// Both counters sit at zero while clear is high, so every RUN phase begins at word 0 of pass 0.
module weight_load_sched_rd_seq
    import pe_array_pkg::*;
#(
    parameter int PASS_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              advance,
    input  logic [KS_W-1:0]   kernel_size,
    input  logic [PASS_W-1:0] num_passes,
    output logic [KS_W-1:0]   rd_addr,
    output logic              last_word,
    output logic              last_pass_word
);

    logic [KS_W-1:0]   r;
    logic [PASS_W-1:0] pass;

    // NOTE: sequential state uses non-blocking assignments so that every register
    // samples its inputs from before the edge, whatever order the statements are in.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r    <= '0;
            pass <= '0;
        end else if (advance) begin
            if (last_word) begin
                r    <= '0;
                pass <= pass + PASS_W'(1);
            end else begin
                r <= r + KS_W'(1);
            end
        end
    end

    assign rd_addr        = r;
    assign last_word      = (r == kernel_size - KS_W'(1));
    assign last_pass_word = last_word && (pass == num_passes - PASS_W'(1));

endmodule

// File: rtl/weight_load_sched.sv
// Weight buffer sequencer: loads kernel_size words into each active PE buffer in turn,
// then replays the stored kernel to all PEs in lockstep for num_passes passes.
module weight_load_sched
    import pe_array_pkg::*;
#(
    parameter  int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter  int BUFFER_DEPTH = DEF_BUFFER_DEPTH,
    parameter  int NUM_PE       = 4,
    parameter  int PASS_W       = 8,
    localparam int PE_W         = $clog2(NUM_PE) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [KS_W-1:0]       kernel_size,
    input  logic [PE_W-1:0]       num_pe,
    input  logic [PASS_W-1:0]     num_passes,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  pe_stall,
    output logic [NUM_PE-1:0]     wb_flush,
    output logic [NUM_PE-1:0]     wb_wr_en,
    output logic [KS_W-1:0]       wb_wr_addr,
    output logic [DATA_WIDTH-1:0] wb_wr_data,
    output logic                  wb_rd_en,
    output logic [KS_W-1:0]       wb_rd_addr,
    output logic                  wb_rd_last,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
);

    sched_state_e      state, state_nxt;

    logic [KS_W-1:0]   k_lat;
    logic [PE_W-1:0]   npe_lat;
    logic [PASS_W-1:0] passes_lat;
    logic [PE_W-1:0]   pe_idx;
    logic [KS_W-1:0]   w;

    logic              cfg_bad;
    logic              start_ok;
    logic              load_last_word;
    logic              last_pe;
    logic              rd_advance;
    logic              rd_clear;
    logic [KS_W-1:0]   rd_r;
    logic              rd_last_word;
    logic              rd_last_pass_word;

    assign cfg_bad = (kernel_size == '0)
                  || (kernel_size > KS_W'(BUFFER_DEPTH))
                  || (num_pe == '0)
                  || (num_pe > PE_W'(NUM_PE))
                  || (num_passes == '0);

    assign start_ok       = (state == ST_IDLE) && start && !cfg_bad;
    assign load_last_word = (w == k_lat - KS_W'(1));
    assign last_pe        = (pe_idx == npe_lat - PE_W'(1));
    assign rd_clear       = (state != ST_RUN);
    assign busy           = (state != ST_IDLE);

    // NOTE: every output of this block gets a default before the case statement;
    // a path that left one unassigned would infer a latch.
    always_comb begin
        state_nxt  = state;
        s_ready    = 1'b0;
        wb_flush   = '0;
        wb_wr_en   = '0;
        wb_wr_addr = '0;
        wb_wr_data = '0;
        wb_rd_en   = 1'b0;
        wb_rd_addr = '0;
        wb_rd_last = 1'b0;
        done       = 1'b0;
        rd_advance = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start_ok) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                wb_flush  = NUM_PE'(1) << pe_idx;
                state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    wb_wr_en   = NUM_PE'(1) << pe_idx;
                    wb_wr_addr = w;
                    wb_wr_data = s_data;
                    if (load_last_word) state_nxt = last_pe ? ST_RUN : ST_FLUSH;
                end
            end
            ST_RUN: begin
                wb_rd_addr = rd_r;
                if (!pe_stall) begin
                    wb_rd_en   = 1'b1;
                    wb_rd_last = rd_last_word;
                    rd_advance = 1'b1;
                    if (rd_last_pass_word) state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: only control registers live here and all of them are reset; the weight
    // storage itself is in the PE buffers and is cleared by the FLUSH pulse instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            k_lat      <= '0;
            npe_lat    <= '0;
            passes_lat <= '0;
            pe_idx     <= '0;
            w          <= '0;
            cfg_err    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cfg_err <= (state == ST_IDLE) && start && cfg_bad;

            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        k_lat      <= kernel_size;
                        npe_lat    <= num_pe;
                        passes_lat <= num_passes;
                        pe_idx     <= '0;
                    end
                end
                ST_FLUSH: w <= '0;
                ST_LOAD: begin
                    if (s_valid) begin
                        if (load_last_word) begin
                            w <= '0;
                            if (!last_pe) pe_idx <= pe_idx + PE_W'(1);
                        end else begin
                            w <= w + KS_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    weight_load_sched_rd_seq #(
        .PASS_W (PASS_W)
    ) u_rd_seq (
        .clk            (clk),
        .rst            (rst),
        .clear          (rd_clear),
        .advance        (rd_advance),
        .kernel_size    (k_lat),
        .num_passes     (passes_lat),
        .rd_addr        (rd_r),
        .last_word      (rd_last_word),
        .last_pass_word (rd_last_pass_word)
    );

endmodule

// File: tb/tb_weight_load_sched.sv
// Directed bench for weight_load_sched: cycle tables for the basic jobs plus
// hand-written sequences for stall, config rejection, long kernels, K=1 and mid-job reset.
module tb_weight_load_sched;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  kernel_size;
    logic [2:0]  num_pe;
    logic [7:0]  num_passes;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        pe_stall;
    logic [3:0]  wb_flush;
    logic [3:0]  wb_wr_en;
    logic [7:0]  wb_wr_addr;
    logic [15:0] wb_wr_data;
    logic        wb_rd_en;
    logic [7:0]  wb_rd_addr;
    logic        wb_rd_last;
    logic        busy;
    logic        done;
    logic        cfg_err;

    int checks = 0;
    int errors = 0;

    weight_load_sched #(
        .DATA_WIDTH   (16),
        .BUFFER_DEPTH (16),
        .NUM_PE       (4),
        .PASS_W       (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .kernel_size (kernel_size),
        .num_pe      (num_pe),
        .num_passes  (num_passes),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .pe_stall    (pe_stall),
        .wb_flush    (wb_flush),
        .wb_wr_en    (wb_wr_en),
        .wb_wr_addr  (wb_wr_addr),
        .wb_wr_data  (wb_wr_data),
        .wb_rd_en    (wb_rd_en),
        .wb_rd_addr  (wb_rd_addr),
        .wb_rd_last  (wb_rd_last),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       sv;
        logic       stall;
        logic       rdy;
        logic [3:0] fl;
        logic [3:0] we;
        logic [7:0] wa;
        logic       re;
        logic [7:0] ra;
        logic       rl;
        logic       bsy;
        logic       dn;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // {s_ready, flush, wr_en, wr_addr, wr_data, rd_en, rd_addr, rd_last, busy, done, cfg_err}
    function automatic logic [45:0] out_bus();
        return {s_ready, wb_flush, wb_wr_en, wb_wr_addr, wb_wr_data,
                wb_rd_en, wb_rd_addr, wb_rd_last, busy, done, cfg_err};
    endfunction

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic st, input logic sv, input logic stl, input logic rdy,
                       input logic [3:0] fl, input logic [3:0] we, input logic [7:0] wa,
                       input logic re, input logic [7:0] ra, input logic rl,
                       input logic bsy, input logic dn);
        vec_t v;
        v.start = st;  v.sv = sv;   v.stall = stl; v.rdy = rdy;
        v.fl    = fl;  v.we = we;   v.wa    = wa;  v.re  = re;
        v.ra    = ra;  v.rl = rl;   v.bsy   = bsy; v.dn  = dn;
        tbl.push_back(v);
    endtask

    task automatic run_table(input string tag, input int first, input int last);
        logic [15:0] exp_data;
        for (int i = first; i <= last; i++) begin
            start    = tbl[i].start;
            s_valid  = tbl[i].sv;
            pe_stall = tbl[i].stall;
            s_data   = 16'hA000 + 16'(i);
            exp_data = (tbl[i].we != 4'b0) ? s_data : 16'h0;
            @(negedge clk);
            check($sformatf("%s[%0d]", tag, i - first), 64'(out_bus()),
                  64'({tbl[i].rdy, tbl[i].fl, tbl[i].we, tbl[i].wa, exp_data,
                       tbl[i].re, tbl[i].ra, tbl[i].rl, tbl[i].bsy, tbl[i].dn, 1'b0}));
            next_cyc();
        end
        start = 1'b0;
    endtask

    // Runs a full job with s_valid held high and collects write/read statistics.
    task automatic run_job(input string tag, input logic [7:0] k, input logic [2:0] npe,
                           input logic [7:0] np, input int exp_done, input bit poke);
        int cyc = 0;
        int done_at = -1;
        int nwr = 0, nrd = 0, nlast = 0, maxwa = 0, maxra = 0, data_bad = 0;
        logic [3:0] first_fl = 4'b0;
        kernel_size = k;
        num_pe      = npe;
        num_passes  = np;
        s_valid     = 1'b1;
        pe_stall    = 1'b0;
        start       = 1'b1;
        while (done_at < 0 && cyc < 400) begin
            s_data = 16'hC000 + 16'(cyc);
            @(negedge clk);
            if (wb_wr_en != 4'b0) begin
                nwr++;
                if (int'(wb_wr_addr) > maxwa) maxwa = int'(wb_wr_addr);
                if (wb_wr_data !== s_data) data_bad++;
            end
            if (wb_rd_en) begin
                nrd++;
                if (int'(wb_rd_addr) > maxra) maxra = int'(wb_rd_addr);
                if (wb_rd_last) nlast++;
            end
            if (wb_flush != 4'b0 && first_fl == 4'b0) first_fl = wb_flush;
            if (done) done_at = cyc;
            next_cyc();
            cyc++;
            start = poke && (cyc == 10 || cyc == exp_done - 5);
        end
        start = 1'b0;
        check({tag, "_done_cycle"}, 64'(done_at), 64'(exp_done));
        check({tag, "_writes"},     64'(nwr),     64'(int'(k) * int'(npe)));
        check({tag, "_reads"},      64'(nrd),     64'(int'(k) * int'(np)));
        check({tag, "_rd_last"},    64'(nlast),   64'(np));
        check({tag, "_max_wr_addr"}, 64'(maxwa),  64'(int'(k) - 1));
        check({tag, "_max_rd_addr"}, 64'(maxra),  64'(int'(k) - 1));
        check({tag, "_first_flush"}, 64'(first_fl), 64'(4'b0001));
        check({tag, "_wr_data"},    64'(data_bad), 64'(0));
        @(negedge clk);
        check({tag, "_idle_after"}, 64'(out_bus()), 64'(0));
        next_cyc();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] cfg_ks[5];
        logic [2:0] cfg_np[5];
        logic [7:0] cfg_ps[5];
        logic [7:0] exp_ra[5];

        // Test 1: K=3, two PEs, two passes, s_valid always high (entries 0..16)
        add(1,1,0, 0,4'h0,4'h0,8'd0, 0,8'd0,0, 0,0);
        add(0,1,0, 0,4'h1,4'h0,8'd0, 0,8'd0,0, 1,0);
        add(0,1,0, 1,4'h0,4'h1,8'd0, 0,8'd0,0, 1,0);
        add(0,1,0, 1,4'h0,4'h1,8'd1, 0,8'd0,0, 1,0);
        add(0,1,0, 1,4'h0,4'h1,8'd2, 0,8'd0,0, 1,0);
        add(0,1,0, 0,4'h2,4'h0,8'd0, 0,8'd0,0, 1,0);
        add(0,1,0, 1,4'h0,4'h2,8'd0, 0,8'd0,0, 1,0);
        add(0,1,0, 1,4'h0,4'h2,8'd1, 0,8'd0,0, 1,0);
        add(0,1,0, 1,4'h0,4'h2,8'd2, 0,8'd0,0, 1,0);
        add(0,1,0, 0,4'h0,4'h0,8'd0, 1,8'd0,0, 1,0);
        add(0,1,0, 0,4'h0,4'h0,8'd0, 1,8'd1,0, 1,0);
        add(0,1,0, 0,4'h0,4'h0,8'd0, 1,8'd2,1, 1,0);
        add(0,1,0, 0,4'h0,4'h0,8'd0, 1,8'd0,0, 1,0);
        add(0,1,0, 0,4'h0,4'h0,8'd0, 1,8'd1,0, 1,0);
        add(0,1,0, 0,4'h0,4'h0,8'd0, 1,8'd2,1, 1,0);
        add(0,1,0, 0,4'h0,4'h0,8'd0, 0,8'd0,0, 1,1);
        add(0,1,0, 0,4'h0,4'h0,8'd0, 0,8'd0,0, 0,0);
        // Test 2: same job, s_valid toggling; valid high during the first FLUSH (entries 17..38)
        add(1,0,0, 0,4'h0,4'h0,8'd0, 0,8'd0,0, 0,0);
        add(0,1,0, 0,4'h1,4'h0,8'd0, 0,8'd0,0, 1,0);
        add(0,0,0, 1,4'h0,4'h0,8'd0, 0,8'd0,0, 1,0);
        add(0,1,0, 1,4'h0,4'h1,8'd0, 0,8'd0,0, 1,0);
        add(0,0,0, 1,4'h0,4'h0,8'd0, 0,8'd0,0, 1,0);
        add(0,1,0, 1,4'h0,4'h1,8'd1, 0,8'd0,0, 1,0);
        add(0,0,0, 1,4'h0,4'h0,8'd0, 0,8'd0,0, 1,0);
        add(0,1,0, 1,4'h0,4'h1,8'd2, 0,8'd0,0, 1,0);
        add(0,0,0, 0,4'h2,4'h0,8'd0, 0,8'd0,0, 1,0);
        add(0,1,0, 1,4'h0,4'h2,8'd0, 0,8'd0,0, 1,0);
        add(0,0,0, 1,4'h0,4'h0,8'd0, 0,8'd0,0, 1,0);
        add(0,1,0, 1,4'h0,4'h2,8'd1, 0,8'd0,0, 1,0);
        add(0,0,0, 1,4'h0,4'h0,8'd0, 0,8'd0,0, 1,0);
        add(0,1,0, 1,4'h0,4'h2,8'd2, 0,8'd0,0, 1,0);
        add(0,0,0, 0,4'h0,4'h0,8'd0, 1,8'd0,0, 1,0);
        add(0,1,0, 0,4'h0,4'h0,8'd0, 1,8'd1,0, 1,0);
        add(0,0,0, 0,4'h0,4'h0,8'd0, 1,8'd2,1, 1,0);
        add(0,1,0, 0,4'h0,4'h0,8'd0, 1,8'd0,0, 1,0);
        add(0,0,0, 0,4'h0,4'h0,8'd0, 1,8'd1,0, 1,0);
        add(0,1,0, 0,4'h0,4'h0,8'd0, 1,8'd2,1, 1,0);
        add(0,0,0, 0,4'h0,4'h0,8'd0, 0,8'd0,0, 1,1);
        add(0,1,0, 0,4'h0,4'h0,8'd0, 0,8'd0,0, 0,0);

        rst = 1'b1; start = 1'b0; s_valid = 1'b0; pe_stall = 1'b0; s_data = 16'h0;
        kernel_size = 8'd0; num_pe = 3'd0; num_passes = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", 64'(out_bus()), 64'(0));
        next_cyc();

        kernel_size = 8'd3; num_pe = 3'd2; num_passes = 8'd2;
        run_table("basic", 0, 16);
        run_table("valid_toggle", 17, 38);

        // Test 3: three-cycle stall while rd_addr is 1
        kernel_size = 8'd3; num_pe = 3'd1; num_passes = 8'd2;
        s_valid = 1'b1; start = 1'b1;
        next_cyc();
        start = 1'b0;
        repeat (4) next_cyc();
        @(negedge clk);
        check("stall_pre_addr0", 64'({wb_rd_en, wb_rd_addr}), 64'({1'b1, 8'd0}));
        next_cyc();
        pe_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("stall_rd_en[%0d]", i), 64'({wb_rd_en, busy}), 64'({1'b0, 1'b1}));
            next_cyc();
        end
        pe_stall = 1'b0;
        exp_ra = '{8'd1, 8'd2, 8'd0, 8'd1, 8'd2};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stall_resume[%0d]", i), 64'({wb_rd_en, wb_rd_addr, wb_rd_last}),
                  64'({1'b1, exp_ra[i], exp_ra[i] == 8'd2}));
            next_cyc();
        end
        @(negedge clk);
        check("stall_done", 64'({done, busy}), 64'({1'b1, 1'b1}));
        next_cyc();

        // Test 4: rejected configurations
        cfg_ks = '{8'd0,  8'd17, 8'd3, 8'd3, 8'd3};
        cfg_np = '{3'd2,  3'd2,  3'd2, 3'd0, 3'd5};
        cfg_ps = '{8'd2,  8'd2,  8'd0, 8'd1, 8'd1};
        for (int i = 0; i < 5; i++) begin
            kernel_size = cfg_ks[i]; num_pe = cfg_np[i]; num_passes = cfg_ps[i];
            s_valid = 1'b1; start = 1'b1;
            @(negedge clk);
            check($sformatf("cfg_start[%0d]", i), 64'(out_bus()), 64'(0));
            next_cyc();
            start = 1'b0;
            @(negedge clk);
            check($sformatf("cfg_err[%0d]", i), 64'(out_bus()), 64'(1));
            next_cyc();
            @(negedge clk);
            check($sformatf("cfg_after[%0d]", i), 64'(out_bus()), 64'(0));
            next_cyc();
        end

        // Test 5: full-depth kernel on all PEs with stray starts mid-job
        run_job("k16", 8'd16, 3'd4, 8'd1, 85, 1'b1);
        // K=1 boundary: one word per PE, rd_last on every read
        run_job("k1", 8'd1, 3'd2, 8'd3, 8, 1'b0);

        // Test 6: reset during LOAD of PE1, then a fresh job
        kernel_size = 8'd3; num_pe = 3'd2; num_passes = 8'd1;
        s_valid = 1'b1; start = 1'b1;
        next_cyc();
        start = 1'b0;
        repeat (5) next_cyc();
        @(negedge clk);
        check("pre_rst_load_pe1", 64'({wb_wr_en, wb_wr_addr}), 64'({4'b0010, 8'd0}));
        next_cyc();
        rst = 1'b1;
        next_cyc();
        rst = 1'b0;
        @(negedge clk);
        check("rst_outputs", 64'(out_bus()), 64'(0));
        next_cyc();
        run_job("after_rst", 8'd2, 3'd2, 8'd1, 9, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
